// File: rtl/shift_reg_pkg.sv
// Shared definitions for the sequenced load/shift register.
// Holds the shift-mode encodings used on the mode input and by the
// single-bit step shifter, and the two-state controller encoding.
package shift_reg_pkg;

   // Shift-mode encodings; values 5..7 are reserved and leave the data untouched.
   localparam logic [2:0] MODE_LSL = 3'd0;
   localparam logic [2:0] MODE_LSR = 3'd1;
   localparam logic [2:0] MODE_ASR = 3'd2;
   localparam logic [2:0] MODE_ROL = 3'd3;
   localparam logic [2:0] MODE_ROR = 3'd4;

   // Controller states: waiting for work, or stepping through a sequenced shift.
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shifter.
// Ports:
//   p        - current register value
//   op       - shift mode (MODE_* encoding)
//   ser_in_l - fill bit entering at the MSB for logical right shifts
//   ser_in_r - fill bit entering at the LSB for logical left shifts
//   next_p   - register value after one step
//   out_bit  - bit expelled by this step (0 for reserved modes)
module shift_step
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] p,
   input  logic [2:0]       op,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   output logic [WIDTH-1:0] next_p,
   output logic             out_bit
);

   // One step of the selected shift; reserved modes pass the value through
   // so the caller can keep counting without disturbing the data.
   always_comb begin
      next_p  = p;
      out_bit = 1'b0;
      case (op)
         MODE_LSL: begin
            next_p  = {p[WIDTH-2:0], ser_in_r};
            out_bit = p[WIDTH-1];
         end
         MODE_LSR: begin
            next_p  = {ser_in_l, p[WIDTH-1:1]};
            out_bit = p[0];
         end
         MODE_ASR: begin
            next_p  = {p[WIDTH-1], p[WIDTH-1:1]};
            out_bit = p[0];
         end
         MODE_ROL: begin
            next_p  = {p[WIDTH-2:0], p[WIDTH-1]};
            out_bit = p[WIDTH-1];
         end
         MODE_ROR: begin
            next_p  = {p[0], p[WIDTH-1:1]};
            out_bit = p[0];
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_seq.sv
// Load/shift register with legacy single-step controls and a sequenced
// multi-bit shift engine (one bit per cycle, start/busy/done handshake).
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   ld, par_in        - parallel load (highest priority, aborts a sequence)
//   shl_en, shr_en    - legacy single-step shifts, honoured only when idle
//   ser_in_l/ser_in_r - MSB / LSB fill bits
//   start, mode, amt  - sequenced shift request, accepted only when idle
//   par_out           - register contents; MSB_out/LSB_out are its end taps
//   busy, done        - sequence in progress / one-cycle completion pulse
//   shifted_out       - bit expelled by the most recent shift step
// WIDTH must be at least 2 and 2**CNT_W must exceed WIDTH.
module shift_reg_seq
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] par_in,
   input  logic             shl_en,
   input  logic             shr_en,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] amt,
   output logic [WIDTH-1:0] par_out,
   output logic             MSB_out,
   output logic             LSB_out,
   output logic             busy,
   output logic             done,
   output logic             shifted_out
);

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [2:0]        mode_q, mode_n;
   logic [WIDTH-1:0]  data_q, data_n;
   logic              out_q, out_n;
   logic              done_q, done_n;

   logic [2:0]        step_op;
   logic              step_fill_r;
   logic [WIDTH-1:0]  step_p;
   logic              step_bit;

   // The one step shifter serves both paths: while sequencing it follows the
   // latched mode; when idle the legacy left shift is LSL with a zero fill and
   // the legacy right shift is LSR, left winning when both are requested.
   always_comb begin
      step_op     = MODE_LSR;
      step_fill_r = 1'b0;
      if (state == S_SHIFT) begin
         step_op     = mode_q;
         step_fill_r = ser_in_r;
      end else if (shl_en) begin
         step_op = MODE_LSL;
      end
   end

   shift_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .p       (data_q),
      .op      (step_op),
      .ser_in_l(ser_in_l),
      .ser_in_r(step_fill_r),
      .next_p  (step_p),
      .out_bit (step_bit)
   );

   // State, counter, data and handshake registers; reset clears everything,
   // which also drops any sequence in flight without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mode_q <= MODE_LSL;
         data_q <= '0;
         out_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mode_q <= mode_n;
         data_q <= data_n;
         out_q  <= out_n;
         done_q <= done_n;
      end
   end

   // Next-state logic in priority order: load, active shift step, start,
   // legacy steps. A load always returns to idle and never pulses done.
   // The step that brings the counter to zero also finishes the sequence;
   // a zero amount finishes on the first shift-state edge with no step.
   // Reserved modes count normally but keep the data and expelled bit.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mode_n  = mode_q;
      data_n  = data_q;
      out_n   = out_q;
      done_n  = 1'b0;
      if (ld) begin
         data_n  = par_in;
         state_n = S_IDLE;
      end else if (state == S_SHIFT) begin
         if (cnt != '0) begin
            data_n = step_p;
            if (mode_q <= MODE_ROR) begin
               out_n = step_bit;
            end
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end
         end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
         end
      end else if (start) begin
         mode_n  = mode;
         cnt_n   = amt;
         state_n = S_SHIFT;
      end else if (shl_en || shr_en) begin
         data_n = step_p;
         out_n  = step_bit;
      end
   end

   assign par_out     = data_q;
   assign MSB_out     = data_q[WIDTH-1];
   assign LSB_out     = data_q[0];
   assign busy        = (state == S_SHIFT);
   assign done        = done_q;
   assign shifted_out = out_q;

endmodule
